// File: rtl/oled_value_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : oled_value_scheduler_if
// Description : Bundle of the requester, converter and OLED-writer signals
//               around the value scheduler.
//               master modport : the scheduler itself
//               slave  modport : everything around it (requesters, converter,
//                                OLED text writer)
// Ports (from the scheduler's point of view)
//   req           in   NUM_REQ      level request per requester
//   value         in   32*NUM_REQ   packed 32-bit values, value i at [32*i+:32]
//   ack           out  NUM_REQ      one-cycle job-finished pulse
//   conv_value    out  32           value presented to the converter
//   conv_load     out  1            converter load_data
//   conv_complete in   1            converter complete
//   conv_ascii    in   512          converter ASCII text
//   disp_valid    out  1            line available for the OLED writer
//   disp_ready    in   1            OLED writer accepts the line
//   disp_line     out  3            target OLED line (= granted requester)
//   disp_text     out  512          captured ASCII line
//   busy          out  1            scheduler not idle
//   timeout_err   out  1            sticky abort flag
// Revision    : 1.0 - initial release
// ============================================================================
interface oled_value_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] value;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           conv_value;
  logic                  conv_load;
  logic                  conv_complete;
  logic [511:0]          conv_ascii;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [2:0]            disp_line;
  logic [511:0]          disp_text;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  req, value, conv_complete, conv_ascii, disp_ready,
    output ack, conv_value, conv_load, disp_valid, disp_line, disp_text,
           busy, timeout_err
  );

  modport slave (
    output req, value, conv_complete, conv_ascii, disp_ready,
    input  ack, conv_value, conv_load, disp_valid, disp_line, disp_text,
           busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/oled_value_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : oled_value_scheduler
// Description : Shares one decimal_to_ascii converter among NUM_REQ
//               requesters. Round-robin grant in IDLE, converter load pulse of
//               LOAD_HOLD cycles, wait for the stale complete to clear, wait for
//               the new complete (bounded by TIMEOUT), then hand the ASCII line
//               to the OLED writer over a valid/ready handshake.
// Ports
//   clock  in  1   system clock
//   reset  in  1   asynchronous active-high reset
//   bus    master  requester / converter / display signals (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module oled_value_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int LOAD_HOLD = 12,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  oled_value_scheduler_if.master bus
);

  localparam int HOLD_W = $clog2(LOAD_HOLD + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    SEND      = 3'd4
  } state_t;

  state_t             state;
  logic [2:0]         idx;
  logic [2:0]         rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TO_W-1:0]    tout_cnt;

  // Round-robin arbiter: first set request at or after rr_ptr, wrapping.
  logic [7:0]         req_ext;
  logic               grant_any;
  logic [2:0]         grant_idx;
  logic [3:0]         cand;
  logic [31:0]        sel_value;
  logic [3:0]         nxt_sum;
  logic [2:0]         rr_next;
  logic [NUM_REQ-1:0] idx_onehot;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = bus.req;
    grant_any            = 1'b0;
    grant_idx            = 3'd0;
    cand                 = 4'd0;
    // Scan from the farthest candidate down so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (req_ext[cand[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    sel_value = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == 3'(k)) begin
        sel_value = bus.value[32*k +: 32];
      end
    end
  end

  assign nxt_sum = {1'b0, grant_idx} + 4'd1;
  assign rr_next = (nxt_sum == 4'(NUM_REQ)) ? 3'd0 : nxt_sum[2:0];

  always_comb begin
    idx_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (idx == 3'(k)) begin
        idx_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= 3'd0;
      rr_ptr          <= 3'd0;
      hold_cnt        <= '0;
      tout_cnt        <= '0;
      bus.ack         <= '0;
      bus.conv_value  <= 32'd0;
      bus.conv_load   <= 1'b0;
      bus.disp_valid  <= 1'b0;
      bus.disp_line   <= 3'd0;
      bus.disp_text   <= 512'd0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            idx            <= grant_idx;
            bus.conv_value <= sel_value;
            rr_ptr         <= rr_next;
            bus.conv_load  <= 1'b1;
            hold_cnt       <= '0;
            bus.busy       <= 1'b1;
            state          <= LOAD;
          end
        end

        LOAD: begin
          if (hold_cnt == HOLD_W'(LOAD_HOLD - 1)) begin
            bus.conv_load <= 1'b0;
            tout_cnt      <= '0;
            state         <= WAIT_CLR;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        // Both wait states share one timeout budget; the abort takes
        // precedence over a completion seen in the very same cycle.
        WAIT_CLR, WAIT_DONE: begin
          if (tout_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.ack         <= idx_onehot;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            tout_cnt <= tout_cnt + 1'b1;
            if (state == WAIT_CLR) begin
              // A complete still high from the previous job is not "done".
              if (!bus.conv_complete) begin
                state <= WAIT_DONE;
              end
            end else if (bus.conv_complete) begin
              bus.disp_text  <= bus.conv_ascii;
              bus.disp_line  <= idx;
              bus.disp_valid <= 1'b1;
              state          <= SEND;
            end
          end
        end

        SEND: begin
          if (bus.disp_ready) begin
            bus.disp_valid <= 1'b0;
            bus.ack        <= idx_onehot;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
